// File: rtl/data_bus_pkg.sv
// Shared types and helpers for the registered 6809 read-data multiplexer.
// Holds the FSM state type, the default idle bus value and index sizing.
package data_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] IDLE_DATA_DEF = 8'hFF;

    // Index width able to encode sources 0..n-1 plus the "none" code n.
    function automatic int src_idx_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/data_bus_prio_enc.sv
// Lowest-index-wins priority encoder for the source chip selects.
// idx equals N ("none") when no select is active.
module data_bus_prio_enc
    import data_bus_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = src_idx_w(N)
) (
    input  logic [N-1:0]  sel,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic          multi
);

    // Scan from the top so the lowest active index is the last to win.
    always_comb begin
        valid = |sel;
        multi = (sel & (sel - N'(1))) != '0;
        idx   = IW'(N);
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/data_bus_mux.sv
// Registered read-data multiplexer with per-source wait states and MRDY.
// Optional debug ports lastSrc/readCount when DATA_BUS_DEBUG_EN is defined.
module data_bus_mux
    import data_bus_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NUM_SRC = 4,
    parameter int WAIT_W = 3,
    parameter logic [WIDTH-1:0] IDLE_DATA = WIDTH'(IDLE_DATA_DEF)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cycleStart,
    input  logic [NUM_SRC*WIDTH-1:0]  srcData,
    input  logic [NUM_SRC-1:0]        srcSelect,
    input  logic [NUM_SRC*WAIT_W-1:0] srcWait,
    input  logic                      conflictClr,
    output logic [WIDTH-1:0]          dataOut,
    output logic                      mrdy,
    output logic                      conflict
`ifdef DATA_BUS_DEBUG_EN
    ,
    output logic [src_idx_w(NUM_SRC)-1:0] lastSrc,
    output logic [15:0]               readCount
`endif
);

    localparam int IW = src_idx_w(NUM_SRC);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]     lock_q, lock_d;
    logic              mrdy_d, conf_d;
    logic              cap;
    logic [WIDTH-1:0]  cap_data;

    logic              enc_valid, enc_multi;
    logic [IW-1:0]     enc_idx;
    logic [WIDTH-1:0]  enc_data, lock_data;
    logic [WAIT_W-1:0] enc_wait;
    logic              accept;

    data_bus_prio_enc #(.N(NUM_SRC)) u_enc (
        .sel   (srcSelect),
        .valid (enc_valid),
        .idx   (enc_idx),
        .multi (enc_multi)
    );

    // Route data/wait of the encoder winner and data of the locked source.
    always_comb begin
        enc_data  = IDLE_DATA;
        enc_wait  = '0;
        lock_data = IDLE_DATA;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (enc_valid && enc_idx == IW'(i)) begin
                enc_data = srcData[i*WIDTH +: WIDTH];
                enc_wait = srcWait[i*WAIT_W +: WAIT_W];
            end
            if (lock_q == IW'(i)) lock_data = srcData[i*WIDTH +: WIDTH];
        end
    end

    assign accept = cycleStart && (state_q != WAIT);

    // Next-state, counter, capture and MRDY decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lock_d   = lock_q;
        mrdy_d   = mrdy;
        cap      = 1'b0;
        cap_data = enc_data;
        unique case (state_q)
            IDLE, HOLD: begin
                if (cycleStart) begin
                    lock_d = enc_idx;
                    if (enc_wait == '0) begin
                        cap      = 1'b1;
                        cap_data = enc_data;
                        mrdy_d   = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        cnt_d   = enc_wait;
                        mrdy_d  = 1'b0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= WAIT_W'(1)) begin
                    cap      = 1'b1;
                    cap_data = lock_data;
                    cnt_d    = '0;
                    mrdy_d   = 1'b1;
                    state_d  = HOLD;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                mrdy_d  = 1'b1;
            end
        endcase
    end

    // Sticky conflict: a new multi-hit overrides a same-cycle clear.
    always_comb begin
        conf_d = conflict && !conflictClr;
        if (accept && enc_multi) conf_d = 1'b1;
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lock_q   <= '0;
            dataOut  <= IDLE_DATA;
            mrdy     <= 1'b1;
            conflict <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            mrdy     <= mrdy_d;
            conflict <= conf_d;
            if (cap) dataOut <= cap_data;
        end
    end

`ifdef DATA_BUS_DEBUG_EN
    logic [IW-1:0] cap_src;

    // Source that a capture this cycle would come from.
    always_comb begin
        cap_src = (state_q == WAIT) ? lock_q : enc_idx;
    end

    // Debug trace of the last captured source and a saturating read count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastSrc   <= IW'(NUM_SRC);
            readCount <= '0;
        end else if (cap) begin
            lastSrc <= cap_src;
            if (readCount != 16'hFFFF) readCount <= readCount + 16'd1;
        end
    end
`endif

endmodule
